// File: rtl/classic32_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// classic32_seq_ctrl_if
// Operand/result handshake bundle for the classic32 sequenced multiplier.
//   in_valid  : requester -> controller, operand pair valid
//   in_ready  : controller -> requester, operands can be accepted
//   a, b      : 32-bit unsigned multiplicand / multiplier
//   out_valid : controller -> consumer, product valid
//   out_ready : consumer -> controller, product accepted
//   out       : 64-bit product a*b
// master = requester/consumer side, slave = controller side.
// ---------------------------------------------------------------------------
interface classic32_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/classic32_seq_ctrl.sv
// ---------------------------------------------------------------------------
// classic32_seq_ctrl
// 32x32 unsigned multiplier built from one 16x16 array multiplier that is
// time-multiplexed over four partial-product steps with shift/accumulate.
//
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous, active-high reset
//   bus   : classic32_seq_ctrl_if.slave (operand and result handshakes)
//   busy  : high whenever the controller is not in IDLE
//
// Parameters:
//   PIPE_PP : 0 = accumulate the partial product in the cycle it is formed,
//             1 = register the partial product first (one extra drain cycle)
//
// Optional feature (compile-time macro CLASSIC32_ZERO_SKIP_EN):
//   when defined, an accepted operand pair with a==0 or b==0 goes straight
//   to DONE with a zero product, bypassing the multiplier.
// ---------------------------------------------------------------------------
module classic32_seq_ctrl #(
    parameter int PIPE_PP = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    classic32_seq_ctrl_if.slave        bus,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [1:0]  step;
    logic [1:0]  step_d;
    logic        in_ready;
    logic        out_valid;
    logic        accept;
    logic        load_out;
    logic        zero_op;

    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [31:0] pp_p0;
    logic        acc_en;
    logic [63:0] term;
    logic [63:0] acc;
    logic [63:0] acc_d;
    logic [63:0] out_q;

    // Place a 32-bit partial product at its weight: step 0 -> 0,
    // steps 1/2 (cross terms) -> 16, step 3 -> 32.
    function automatic logic [63:0] weigh_pp(input logic [31:0] pp, input logic [1:0] s);
        case (s)
            2'd0:    weigh_pp = {32'd0, pp};
            2'd3:    weigh_pp = {pp, 32'd0};
            default: weigh_pp = {16'd0, pp, 16'd0};
        endcase
    endfunction

`ifdef CLASSIC32_ZERO_SKIP_EN
    assign zero_op = (bus.a == 32'd0) || (bus.b == 32'd0);
`else
    assign zero_op = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            step  <= 2'd0;
        end else begin
            state <= state_d;
            step  <= step_d;
        end
    end

    // Control FSM: next state and outputs
    always_comb begin
        state_d   = state;
        step_d    = step;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        load_out  = 1'b0;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                // Held low while reset is asserted, even though state is IDLE.
                in_ready = !rst;
                if (bus.in_valid && !rst) begin
                    step_d = 2'd0;
                    if (zero_op) begin
                        state_d  = DONE;
                        load_out = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                step_d = step + 2'd1;
                // Leave BUSY explicitly after step 3 instead of relying on
                // the 2-bit counter wrapping.
                if (step == 2'd3) begin
                    step_d = 2'd0;
                    if (PIPE_PP != 0) begin
                        state_d = DRAIN;
                    end else begin
                        state_d  = DONE;
                        load_out = 1'b1;
                    end
                end
            end
            DRAIN: begin
                state_d  = DONE;
                load_out = 1'b1;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = in_ready & bus.in_valid;

    // ------------------------------------------------------------------
    // Stage p0: operand latch and step-selected 16x16 partial product
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= bus.a;
            b_q <= bus.b;
        end
    end

    // step[0] picks the a half, step[1] picks the b half.
    assign mul_a = step[0] ? a_q[31:16] : a_q[15:0];
    assign mul_b = step[1] ? b_q[31:16] : b_q[15:0];
    assign pp_p0 = {16'd0, mul_a} * {16'd0, mul_b};

    // ------------------------------------------------------------------
    // Stage p1 (PIPE_PP=1 only): registered partial product with its step
    // ------------------------------------------------------------------
    if (PIPE_PP != 0) begin : g_pipe
        logic [31:0] pp_p1;
        logic [1:0]  step_p1;
        logic        vld_p1;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_p1 <= 1'b0;
            end else begin
                vld_p1 <= (state == BUSY);
            end
        end

        always_ff @(posedge clk) begin
            pp_p1   <= pp_p0;
            step_p1 <= step;
        end

        assign acc_en = vld_p1;
        assign term   = weigh_pp(pp_p1, step_p1);
    end else begin : g_direct
        assign acc_en = (state == BUSY);
        assign term   = weigh_pp(pp_p0, step);
    end

    // ------------------------------------------------------------------
    // Accumulate stage: 64-bit shift/accumulate and result register
    // ------------------------------------------------------------------
    always_comb begin
        acc_d = acc;
        if (accept) begin
            acc_d = 64'd0;
        end else if (acc_en) begin
            acc_d = acc + term;
        end
    end

    // The result register is loaded on entry to DONE so that out keeps
    // its value after the handshake and through the next computation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= 64'd0;
            out_q <= 64'd0;
        end else begin
            acc <= acc_d;
            if (load_out) begin
                out_q <= acc_d;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out       = out_q;

endmodule

// File: tb/tb_classic32_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_classic32_seq_ctrl
// Self-checking bench for classic32_seq_ctrl: table of directed vectors,
// hand-written backpressure and mid-operation reset sequences, and a
// randomized run checked against a queue of reference products a*b.
// Honours CLASSIC32_ZERO_SKIP_EN for the zero-operand latency.
// ---------------------------------------------------------------------------
module tb_classic32_seq_ctrl;
    parameter int PIPE_PP = 0;
    localparam int LAT = 4 + PIPE_PP;

`ifdef CLASSIC32_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic busy;

    classic32_seq_ctrl_if bus();

    classic32_seq_ctrl #(.PIPE_PP(PIPE_PP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after each edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected accept-to-result delay in edges after the accept edge.
    // With zero skipping, out_valid is already up right after the accept edge.
    function automatic int exp_lat(input logic [31:0] ta, input logic [31:0] tb_);
        if (ZS && (ta == 32'd0 || tb_ == 32'd0)) return 0;
        return LAT;
    endfunction

    task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("start_in_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.a = ta;
        bus.b = tb_;
        tick();
        // Operands change after the accept edge; the result must not care.
        bus.in_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            chk("busy_in_ready_low", 64'(bus.in_ready), 64'd0);
            chk("busy_flag_high", 64'(busy), 64'd1);
            tick();
            lat++;
        end
    endtask

    function automatic logic [31:0] rand_op();
        int sel = $urandom_range(0, 7);
        if (sel == 0) return 32'd0;
        if (sel == 1) return 32'hFFFF_FFFF;
        return $urandom;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [63:0] held;
        logic [63:0] exp;
        logic [63:0] q[$];
        int accepted;
        int got;
        int cycles;
        logic prev_stall;
        logic [63:0] prev_out;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = 32'd0;
        bus.b         = 32'd0;
        bus.out_ready = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out", bus.out, 64'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("post_rst_busy", 64'(busy), 64'd0);

        // out_ready without out_valid has no effect
        bus.out_ready = 1'b1;
        tick();
        chk("idle_out_ready_ignored", 64'(bus.out_valid), 64'd0);
        chk("idle_still_ready", 64'(bus.in_ready), 64'd1);

        // ---------------- directed vector table ----------------
        vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[1] = '{32'h0000_FFFF, 32'h0002_0003, 64'h0000_0002_0000_FFFD};
        vecs[2] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
        vecs[3] = '{32'h0000_0000, 32'h0000_1234, 64'h0000_0000_0000_0000};
        vecs[4] = '{32'h0001_0001, 32'h0001_0001, 64'h0000_0001_0002_0001};
        vecs[5] = '{32'hFFFF_0000, 32'h0000_FFFF, 64'h0000_FFFE_0001_0000};
        vecs[6] = '{32'h0000_FFFF, 32'hFFFF_0000, 64'h0000_FFFE_0001_0000};
        vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF};
        vecs[8] = '{32'h0000_1234, 32'h0000_0000, 64'h0000_0000_0000_0000};

        for (int i = 0; i < 9; i++) begin
            bus.out_ready = 1'b1;
            start_op(vecs[i].a, vecs[i].b);
            wait_result(lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].a, vecs[i].b)));
            chk($sformatf("vec%0d_out", i), bus.out, vecs[i].prod);
            chk($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid), 64'd1);
            tick();
            chk($sformatf("vec%0d_drop_valid", i), 64'(bus.out_valid), 64'd0);
            chk($sformatf("vec%0d_out_kept", i), bus.out, vecs[i].prod);
            chk($sformatf("vec%0d_idle", i), 64'(busy), 64'd0);
        end

        // ---------------- backpressure ----------------
        bus.out_ready = 1'b0;
        exp = 64'(32'h1234_5678) * 64'(32'h9ABC_DEF0);
        start_op(32'h1234_5678, 32'h9ABC_DEF0);
        wait_result(lat);
        chk("bp_latency", 64'(lat), 64'(LAT));
        chk("bp_out", bus.out, exp);
        held = bus.out;
        bus.in_valid = 1'b1;
        bus.a = 32'd3;
        bus.b = 32'd5;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("bp_valid_held", 64'(bus.out_valid), 64'd1);
            chk("bp_out_stable", bus.out, held);
            chk("bp_no_accept", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_valid", 64'(bus.out_valid), 64'd0);
        chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
        chk("bp_release_out_kept", bus.out, held);
        tick();
        chk("bp_new_accepted", 64'(busy), 64'd1);
        bus.in_valid = 1'b0;
        wait_result(lat);
        chk("bp_new_latency", 64'(lat), 64'(LAT));
        chk("bp_new_out", bus.out, 64'd15);
        tick();

        // ---------------- reset during BUSY step 2 ----------------
        start_op(32'h0001_0000, 32'h0001_0000);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_out", bus.out, 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("midrst_no_valid", 64'(bus.out_valid), 64'd0);
        end
        start_op(32'h0001_0000, 32'h0001_0000);
        wait_result(lat);
        chk("midrst_fresh_latency", 64'(lat), 64'(LAT));
        chk("midrst_fresh_out", bus.out, 64'h0000_0001_0000_0000);
        tick();

        // ---------------- random run against reference queue ----------------
        accepted   = 0;
        got        = 0;
        cycles     = 0;
        prev_stall = 1'b0;
        prev_out   = '0;
        while ((accepted < 1000 || got < accepted) && cycles < 60000) begin
            if (prev_stall) begin
                chk("rand_hold_valid", 64'(bus.out_valid), 64'd1);
                chk("rand_hold_out", bus.out, prev_out);
            end
            bus.in_valid  = (accepted < 1000) && ($urandom_range(0, 3) != 0);
            bus.a         = rand_op();
            bus.b         = rand_op();
            bus.out_ready = ($urandom_range(0, 2) != 0);
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(64'(bus.a) * 64'(bus.b));
                accepted++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("rand_spurious_result", 64'd1, 64'd0);
                end else begin
                    chk("rand_out", bus.out, q.pop_front());
                end
                got++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = bus.out;
            tick();
            cycles++;
        end
        bus.in_valid = 1'b0;
        chk("rand_accepted", 64'(accepted), 64'd1000);
        chk("rand_results", 64'(got), 64'd1000);
        chk("rand_queue_empty", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
